// File: rtl/divisor_4bits_if.sv
// Handshake and data bundle for the sequential restoring divider.
// The master side issues start with operands A/B. The slave side (the divider)
// returns Q/R together with the busy, done and div_zero status flags.
interface divisor_4bits_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, A, B,
        input  Q, R, busy, done, div_zero
    );

    modport slave (
        input  start, A, B,
        output Q, R, busy, done, div_zero
    );
endinterface

// File: rtl/divisor_4bits.sv
// Sequential restoring (shift-subtract) unsigned divider: Q = A / B, R = A % B.
// The divider produces one quotient bit per clock. A division takes WIDTH CALC
// cycles, and done pulses for one cycle when Q/R are updated.
// Optional macro DIV_ZERO_DETECT_EN: when B == 0 is accepted, the divider skips
// CALC and loads Q = all ones and R = A on the accepting edge. It also raises
// div_zero. When the macro is undefined, B == 0 runs the normal path and gives
// the same Q/R, and div_zero is tied low.
module divisor_4bits #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    divisor_4bits_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] rem_reg, quo_reg, div_reg;
    logic [WIDTH-1:0] q_reg, r_reg;
    logic [CW-1:0]    cnt_reg;
    logic             done_reg;

    logic             accept;
    logic             zero_skip;
    logic             last_step;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [WIDTH-1:0] rem_new;
    logic [WIDTH-1:0] quo_new;

    // Shift the {rem, quo} pair left by one. The MSB that leaves quo becomes
    // the new LSB of the partial remainder. This keeps WIDTH+1 bits, so no
    // bit of the partial remainder is lost before the sign test.
    assign rem_sh   = {rem_reg, quo_reg[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, div_reg};
    // The trial value is non-negative when there is no borrow. A set MSB in
    // the shifted remainder always exceeds a WIDTH-bit divisor.
    assign trial_ge = rem_sh[WIDTH] | ~trial[WIDTH];
    assign rem_new  = trial_ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];

    // The quotient register shifts left, and the new quotient bit enters at
    // the LSB.
    assign quo_new[0] = trial_ge;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_quo_shift
            assign quo_new[gi] = quo_reg[gi-1];
        end
    endgenerate

    assign last_step = (cnt_reg == CW'(WIDTH - 1));

`ifdef DIV_ZERO_DETECT_EN
    assign zero_skip = (bus.B == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // State register for the IDLE/CALC/DONE controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A request is taken only when the divider is not busy.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = zero_skip ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = zero_skip ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DIV_ZERO_DETECT_EN
    logic dz_reg;
    assign bus.div_zero = dz_reg;
`else
    assign bus.div_zero = 1'b0;
`endif

    // Datapath: load operands on accept and iterate one bit per CALC edge.
    // Q/R are published only on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            div_reg  <= '0;
            cnt_reg  <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            done_reg <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                rem_reg <= '0;
                quo_reg <= bus.A;
                div_reg <= bus.B;
                cnt_reg <= '0;
`ifdef DIV_ZERO_DETECT_EN
                if (zero_skip) begin
                    q_reg    <= '1;
                    r_reg    <= bus.A;
                    done_reg <= 1'b1;
                    dz_reg   <= 1'b1;
                end
`endif
            end else if (state_reg == CALC) begin
                rem_reg <= rem_new;
                quo_reg <= quo_new;
                cnt_reg <= cnt_reg + CW'(1);
                if (last_step) begin
                    q_reg    <= quo_new;
                    r_reg    <= rem_new;
                    done_reg <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
                    dz_reg   <= 1'b0;
`endif
                end
            end
        end
    end

    assign bus.Q    = q_reg;
    assign bus.R    = r_reg;
    assign bus.busy = (state_reg == CALC);
    assign bus.done = done_reg;
endmodule

// File: tb/tb_divisor_4bits.sv
// Self-checking bench for divisor_4bits. It applies directed cases, a
// back-to-back sweep and random operands. The reference is plain integer
// division, with the divide-by-zero convention Q = all ones and R = A.
module tb_divisor_4bits;
    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    divisor_4bits_if #(.WIDTH(W)) bus();

    divisor_4bits #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the arithmetic definition.
    function automatic void model(input int a, input int b, output int q, output int r, output int dz);
        if (b == 0) begin
            q  = MAXV;
            r  = a;
            dz = DZ_EN ? 1 : 0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 0;
        end
    endfunction

    function automatic int lat_of(input int b);
        return (DZ_EN && b == 0) ? 0 : W;
    endfunction

    // Present a request for exactly one rising edge. The task returns at the
    // falling edge that follows the accepting edge.
    task automatic start_op(input int a, input int b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = W'(a);
        bus.B     = W'(b);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done, then check latency, busy cycles, the result
    // and that done lasts one cycle.
    task automatic wait_done(input string tag, input int a, input int b, input int exp_lat, input int exp_busy);
        int lat;
        int busy_n;
        int q;
        int r;
        int dz;
        lat    = 0;
        busy_n = 0;
        model(a, b, q, r, dz);
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
        chk({tag, ".done_seen"}, 32'(bus.done), 32'd1);
        if (exp_lat >= 0) begin
            chk({tag, ".latency"}, lat, exp_lat);
            chk({tag, ".busy_cycles"}, busy_n, exp_busy);
        end
        chk({tag, ".Q"}, 32'(bus.Q), q);
        chk({tag, ".R"}, 32'(bus.R), r);
        chk({tag, ".div_zero"}, 32'(bus.div_zero), dz);
        $display("div %s: %0d/%0d -> Q=%0d R=%0d dz=%0b lat=%0d", tag, a, b, bus.Q, bus.R, bus.div_zero, lat);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int sa [4] = '{15, 7, 0, 15};
        int sb [4] = '{1, 9, 5, 15};
        int idx;
        int gap;
        int pa;
        int pb;
        int a;
        int b;
        bit saw;

        // Reset
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        chk("reset.Q", 32'(bus.Q), 0);
        chk("reset.R", 32'(bus.R), 0);
        chk("reset.busy", 32'(bus.busy), 0);
        chk("reset.done", 32'(bus.done), 0);
        chk("reset.div_zero", 32'(bus.div_zero), 0);
        rst = 1'b0;

        // 13 / 3, then the result must hold while idle
        start_op(13, 3);
        wait_done("13/3", 13, 3, W, W);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold.Q", 32'(bus.Q), 4);
            chk("hold.R", 32'(bus.R), 1);
        end

        // Sequential directed runs
        for (int i = 0; i < 4; i++) begin
            start_op(sa[i], sb[i]);
            wait_done("seq", sa[i], sb[i], lat_of(sb[i]), lat_of(sb[i]));
        end

        // Divide by zero
        start_op(9, 0);
        wait_done("9/0", 9, 0, lat_of(0), lat_of(0));

        // Request during CALC is ignored
        start_op(12, 5);
        start_op(6, 2);
        wait_done("ignore_mid", 12, 5, W - 2, W - 2);

        // Reset during the second CALC cycle aborts without done
        start_op(14, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.Q", 32'(bus.Q), 0);
        chk("abort.R", 32'(bus.R), 0);
        chk("abort.busy", 32'(bus.busy), 0);
        chk("abort.done", 32'(bus.done), 0);
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw = 1'b1;
        end
        chk("abort.no_done", 32'(saw), 0);
        start_op(14, 4);
        wait_done("14/4", 14, 4, W, W);

        // Back-to-back sweep of all A with B != 0, start held high
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = '0;
        bus.B     = W'(1);
        idx = 0;
        gap = 0;
        while (idx < 16 * 15) begin
            @(negedge clk);
            gap++;
            if (bus.done === 1'b1) begin
                pa = idx / 15;
                pb = idx % 15 + 1;
                chk("b2b.gap", gap, W + 1);
                chk("b2b.identity", int'(bus.Q) * pb + int'(bus.R), pa);
                chk("b2b.rem_lt_b", 32'(int'(bus.R) < pb), 1);
                idx++;
                gap = 0;
                if (idx < 16 * 15) begin
                    bus.A = W'(idx / 15);
                    bus.B = W'(idx % 15 + 1);
                end else begin
                    bus.start = 1'b0;
                end
            end else if (gap > 3 * W) begin
                chk("b2b.timeout", 32'(bus.done), 1);
                idx       = 16 * 15;
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // Random single operations, including B == 0
        repeat (40) begin
            a = int'($urandom_range(0, MAXV));
            b = int'($urandom_range(0, MAXV));
            start_op(a, b);
            wait_done("rand", a, b, lat_of(b), lat_of(b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
